// File: rtl/operand_seq_gen.sv
// Operand-pair stimulus source (random LFSR or exhaustive sweep) with valid/ready output.
// Optional stall counter output enabled by defining OPGEN_STALL_CNT_EN.
module operand_seq_gen #(
    parameter int          WIDTH   = 3,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          MOD     = 7,
    parameter int          NUM_VEC = 250
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             done,
    output logic [15:0]      count
`ifdef OPGEN_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    localparam int          IW      = 2 * WIDTH;
    localparam logic [15:0] T_RAND  = 16'(NUM_VEC);
    localparam logic [15:0] T_SWEEP = 16'(2 ** IW);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic            mode_q;
    logic [15:0]     lfsr;
    logic [IW-1:0]   idx;

    logic            xfer;
    logic            last;
    logic [15:0]     count_inc;
    logic [15:0]     lfsr_nx;
    logic [IW-1:0]   idx_nx;
    logic [15:0]     t_total;

    function automatic logic [WIDTH-1:0] rand_a(input logic [15:0] l);
        return WIDTH'(int'(l[WIDTH-1:0]) % MOD);
    endfunction

    function automatic logic [WIDTH-1:0] rand_b(input logic [15:0] l);
        return l[WIDTH+7:8];
    endfunction

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        xfer      = (state == RUN) && valid && ready;
        count_inc = (count == 16'hFFFF) ? count : count + 16'd1;
        lfsr_nx   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        idx_nx    = idx + IW'(1);
        t_total   = mode_q ? T_SWEEP : T_RAND;
        last      = (count_inc == t_total);
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_q    <= 1'b0;
            lfsr      <= SEED;
            idx       <= '0;
            a         <= '0;
            b         <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
`ifdef OPGEN_STALL_CNT_EN
            stall_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start && !stop) begin
                        state  <= RUN;
                        mode_q <= mode;
                        lfsr   <= SEED;
                        idx    <= '0;
                        count  <= '0;
                        valid  <= 1'b1;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                        a      <= mode ? '0 : rand_a(SEED);
                        b      <= mode ? '0 : rand_b(SEED);
`ifdef OPGEN_STALL_CNT_EN
                        stall_cnt <= '0;
`endif
                    end else if (stop) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end

                RUN: begin
                    if (xfer) begin
                        count <= count_inc;
                        if (mode_q) begin
                            idx <= idx_nx;
                        end else begin
                            lfsr <= lfsr_nx;
                        end
                        // The final transfer leaves a/b alone so a wrapped vector never appears.
                        if (!last) begin
                            a <= mode_q ? idx_nx[IW-1:WIDTH] : rand_a(lfsr_nx);
                            b <= mode_q ? idx_nx[WIDTH-1:0]  : rand_b(lfsr_nx);
                        end
                    end
`ifdef OPGEN_STALL_CNT_EN
                    if (valid && !ready && stall_cnt != 16'hFFFF) begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
`endif
                    if (stop) begin
                        state <= IDLE;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end else if (xfer && last) begin
                        state <= DONE;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_seq_gen.sv
// Self-checking bench for operand_seq_gen: randomized ready against a precomputed vector model.
module tb_operand_seq_gen;

    localparam int W       = 3;
    localparam int MODV    = 7;
    localparam int NV      = 250;
    localparam int NSWEEP  = 64;
    localparam int MAX_CYC = 5000;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           stop;
    logic           mode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           valid;
    logic           ready;
    logic           busy;
    logic           done;
    logic [15:0]    count;
`ifdef OPGEN_STALL_CNT_EN
    logic [15:0]    stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int ra[NV];
    int rb[NV];

    operand_seq_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .stop  (stop),
        .mode  (mode),
        .a     (a),
        .b     (b),
        .valid (valid),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .count (count)
`ifdef OPGEN_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected k-th vector of a run: LFSR table in random mode, plain counting in sweep mode.
    function automatic int exp_a(input logic m, input int k);
        return m ? k / (2 ** W) : ra[k];
    endfunction

    function automatic int exp_b(input logic m, input int k);
        return m ? k % (2 ** W) : rb[k];
    endfunction

    task automatic build_model();
        int l;
        l = 'hACE1;
        for (int i = 0; i < NV; i++) begin
            ra[i] = (l % (2 ** W)) % MODV;
            rb[i] = (l / 256) % (2 ** W);
            l = (l / 2) ^ ((l % 2) != 0 ? 'hB400 : 0);
        end
    endtask

    task automatic pulse_start(input logic m);
        start = 1'b1;
        mode  = m;
        step();
        start = 1'b0;
        mode  = 1'b0;
    endtask

    // Runs a full stream; pct is the ready probability, bubble_at forces 5 ready-low cycles there.
    task automatic run_stream(input logic m, input int t, input int pct, input int bubble_at,
                              output int stalls);
        int k;
        int cyc;
        int bubble_left;
        logic r;
        k = 0;
        cyc = 0;
        stalls = 0;
        bubble_left = 5;
        pulse_start(m);
        while (k < t && cyc < MAX_CYC) begin
            check("run_valid", 32'(valid), 1);
            check("run_busy", 32'(busy), 1);
            check("run_a", 32'(a), exp_a(m, k));
            check("run_b", 32'(b), exp_b(m, k));
            check("run_count", 32'(count), k);
            if (k == bubble_at && bubble_left > 0) begin
                r = 1'b0;
                bubble_left--;
            end else begin
                r = ($urandom_range(99) < pct);
            end
            ready = r;
            step();
            if (r) k++;
            else stalls++;
            cyc++;
        end
        ready = 1'b0;
        check("run_timeout", k, t);
        check("end_done", 32'(done), 1);
        check("end_valid", 32'(valid), 0);
        check("end_busy", 32'(busy), 0);
        check("end_count", 32'(count), t);
        step();
        check("hold_done", 32'(done), 1);
        check("hold_count", 32'(count), t);
    endtask

    initial begin
        int stalls;
        build_model();
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        mode  = 1'b0;
        ready = 1'b0;
        step();
        step();
        check("rst_a", 32'(a), 0);
        check("rst_b", 32'(b), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_count", 32'(count), 0);
        rst_n = 1'b1;
        step();

        // Random mode: full ready except one 5-cycle bubble; spot-check the first two vectors.
        check("model_first", 32'((ra[0] << 4) | rb[0]), 32'h14);
        check("model_second", 32'((ra[1] << 4) | rb[1]), 32'h02);
        run_stream(1'b0, NV, 100, 100, stalls);
`ifdef OPGEN_STALL_CNT_EN
        check("stall_cnt", 32'(stall_cnt), stalls);
`endif

        // Sweep mode restarted straight from DONE, random backpressure.
        run_stream(1'b1, NSWEEP, 70, -1, stalls);
`ifdef OPGEN_STALL_CNT_EN
        check("stall_cnt_sweep", 32'(stall_cnt), stalls);
`endif

        // Abort at count 10 with a simultaneous transfer; start in RUN is ignored.
        stop = 1'b1;
        step();
        stop = 1'b0;
        pulse_start(1'b0);
        ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("ign_start_count", 32'(count), 6);
        check("ign_start_a", 32'(a), ra[6]);
        for (int i = 0; i < 4; i++) step();
        check("pre_abort_count", 32'(count), 10);
        stop = 1'b1;
        step();
        stop  = 1'b0;
        ready = 1'b0;
        check("abort_count", 32'(count), 11);
        check("abort_valid", 32'(valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        step();
        check("abort_hold", 32'(count), 11);
        pulse_start(1'b0);
        check("restart_a", 32'(a), 1);
        check("restart_b", 32'(b), 4);
        check("restart_count", 32'(count), 0);
        check("restart_valid", 32'(valid), 1);

        // start and stop together while idle.
        stop = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_valid", 32'(valid), 0);
        check("ss_busy", 32'(busy), 0);
        step();
        check("ss_idle_valid", 32'(valid), 0);

        // Reset mid-run with a transfer pending.
        pulse_start(1'b0);
        ready = 1'b1;
        for (int i = 0; i < 7; i++) step();
        check("mid_count", 32'(count), 7);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        ready = 1'b0;
        check("mrst_a", 32'(a), 0);
        check("mrst_b", 32'(b), 0);
        check("mrst_valid", 32'(valid), 0);
        check("mrst_count", 32'(count), 0);
        check("mrst_done", 32'(done), 0);
        pulse_start(1'b0);
        check("post_rst_a", 32'(a), 1);
        check("post_rst_b", 32'(b), 4);
        check("post_rst_valid", 32'(valid), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
